// File: rtl/nmos_beamcounter.sv
// nmos_beamcounter: horizontal/vertical colour-clock beam counter with registered sync/blank decodes.
// Optional macro NMOS_BEAMPOS_WR_EN adds the VPOS/LOF load port (VPOS_WR, VPOS_DIN, LOF_DIN).
module nmos_beamcounter #(
  parameter logic [7:0]  HSYNC_START = 8'd18,
  parameter logic [7:0]  HSYNC_STOP  = 8'd35,
  parameter logic [10:0] VSYNC_START = 11'd2,
  parameter logic [10:0] VSYNC_STOP  = 11'd5
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        CCK_EN,
  input  logic        PAL,
  input  logic        LACE,
`ifdef NMOS_BEAMPOS_WR_EN
  input  logic        VPOS_WR,
  input  logic [10:0] VPOS_DIN,
  input  logic        LOF_DIN,
`endif
  output logic [7:0]  HPOS,
  output logic [10:0] VPOS,
  output logic        LOL,
  output logic        LOF,
  output logic        HSYNC_n,
  output logic        VSYNC_n,
  output logic        BLANK_n,
  output logic        EOL,
  output logic        EOF
);

  localparam int unsigned HW = 8;
  localparam int unsigned VW = 11;

  logic          load;
  logic [VW-1:0] load_vpos;
  logic          load_lof;

`ifdef NMOS_BEAMPOS_WR_EN
  assign load      = VPOS_WR;
  assign load_vpos = VPOS_DIN;
  assign load_lof  = LOF_DIN;
`else
  assign load      = 1'b0;
  assign load_vpos = '0;
  assign load_lof  = 1'b0;
`endif

  logic [HW-1:0] hmax;
  logic [VW-1:0] vmax;
  logic [VW-1:0] vblank_end;
  logic          eol_c;
  logic          vwrap_c;
  logic [HW-1:0] hpos_nxt;
  logic [VW-1:0] vpos_nxt;
  logic          lol_nxt;
  logic          lof_nxt;
  logic          eof_nxt;
  logic          hsync_nxt;
  logic          vsync_nxt;
  logic          blank_nxt;

  // Next counter state; a position load overrides counting of VPOS/LOF and suppresses EOF.
  always_comb begin
    hmax       = (!PAL && LOL) ? HW'(227) : HW'(226);
    vmax       = PAL ? (LOF ? VW'(312) : VW'(311)) : (LOF ? VW'(262) : VW'(261));
    vblank_end = PAL ? VW'(25) : VW'(20);
    eol_c      = CCK_EN && (HPOS == hmax);
    vwrap_c    = eol_c && (VPOS >= vmax);
    hpos_nxt   = HPOS;
    vpos_nxt   = VPOS;
    lol_nxt    = LOL;
    lof_nxt    = LOF;
    if (CCK_EN) begin
      if (!eol_c) begin
        hpos_nxt = HPOS + HW'(1);
      end else begin
        hpos_nxt = '0;
        lol_nxt  = PAL ? 1'b0 : ~LOL;
        if (vwrap_c) begin
          vpos_nxt = '0;
          lof_nxt  = LACE ? ~LOF : 1'b1;
        end else begin
          vpos_nxt = VPOS + VW'(1);
        end
      end
    end
    if (load) begin
      vpos_nxt = load_vpos;
      lof_nxt  = load_lof;
    end
    eof_nxt   = vwrap_c && !load;
    hsync_nxt = !((hpos_nxt >= HSYNC_START) && (hpos_nxt < HSYNC_STOP));
    vsync_nxt = !((vpos_nxt >= VSYNC_START) && (vpos_nxt < VSYNC_STOP));
    blank_nxt = !(((hpos_nxt >= HW'(15)) && (hpos_nxt < HW'(53))) || (vpos_nxt < vblank_end));
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      HPOS    <= '0;
      VPOS    <= '0;
      LOL     <= 1'b0;
      LOF     <= 1'b1;
      HSYNC_n <= 1'b1;
      VSYNC_n <= 1'b1;
      BLANK_n <= 1'b0;
      EOL     <= 1'b0;
      EOF     <= 1'b0;
    end else begin
      HPOS    <= hpos_nxt;
      VPOS    <= vpos_nxt;
      LOL     <= lol_nxt;
      LOF     <= lof_nxt;
      HSYNC_n <= hsync_nxt;
      VSYNC_n <= vsync_nxt;
      BLANK_n <= blank_nxt;
      EOL     <= eol_c;
      EOF     <= eof_nxt;
    end
  end

endmodule
